// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared types and constants for the rv32i fetch stage
package rv32i_pkg;
  typedef logic [31:0] word_t;
  typedef logic [31:0] pc_t;
  typedef enum logic {RUN, HALTED} fetch_state_e;
  localparam pc_t RESET_PC_DEFAULT = 32'h0000_0000;
  localparam word_t NOP_INST_DEFAULT = 32'h0000_0013;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry {inst, pc} holding register for responses the output cannot take
module fetch_skid_buf
  import rv32i_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load_i,
  input  logic  clear_i,
  input  word_t inst_i,
  input  pc_t   pc_i,
  output logic  valid_o,
  output word_t inst_o,
  output pc_t   pc_o
);
  logic  valid_q;
  word_t inst_q;
  pc_t   pc_q;
  // clear wins over load; data only moves on load
  always_ff @(posedge clk) begin
    valid_q <= (rst | clear_i) ? 1'b0 : load_i ? 1'b1 : valid_q;
    inst_q  <= load_i ? inst_i : inst_q;
    pc_q    <= load_i ? pc_i : pc_q;
  end
  assign valid_o = valid_q;
  assign inst_o  = inst_q;
  assign pc_o    = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and 1-cycle imem fetch with skid, redirect and halt
module fetch_unit
  import rv32i_pkg::*;
#(
  parameter pc_t   RESET_PC = RESET_PC_DEFAULT,
  parameter word_t NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic        halted
);
  fetch_state_e state_q, state_d;
  pc_t   pc_q, pc_d, pend_pc_q, inst_pc_q, inst_pc_d, skid_pc, tgt;
  word_t inst_q, inst_d, skid_inst;
  logic  pend_q, inst_valid_q, inst_valid_d, skid_valid, run, can_load, flush;
  assign tgt      = redirect_pc & 32'hFFFF_FFFC;
  assign can_load = !(inst_valid_q & stall);
  assign flush    = run & (redirect | halt);
  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (pend_q & !can_load & !flush),
    .clear_i (flush | (can_load & skid_valid)),
    .inst_i  (imem_rdata),
    .pc_i    (pend_pc_q),
    .valid_o (skid_valid),
    .inst_o  (skid_inst),
    .pc_o    (skid_pc)
  );
  // state register
  always_ff @(posedge clk) state_q <= rst ? RUN : state_d;
  // halt is the only way out of RUN; only reset leaves HALTED
  always_comb state_d = (state_q == RUN && halt) ? HALTED : state_q;
  // decoded state outputs
  always_comb begin
    run    = (state_q == RUN);
    halted = (state_q == HALTED);
  end
  // request, next PC and output-register source selection (skid before fresh response)
  always_comb begin
    imem_req     = run & !skid_valid & can_load & !redirect & !halt;
    imem_addr    = pc_q;
    pc_d         = (run & !halt & redirect) ? tgt : imem_req ? pc_q + 32'd4 : pc_q;
    inst_valid_d = flush ? 1'b0 : !can_load ? inst_valid_q : skid_valid | pend_q;
    inst_d       = flush ? NOP_INST : !can_load ? inst_q : skid_valid ? skid_inst : pend_q ? imem_rdata : NOP_INST;
    inst_pc_d    = (flush | !can_load) ? inst_pc_q : skid_valid ? skid_pc : pend_q ? pend_pc_q : inst_pc_q;
  end
  // datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      pend_q       <= 1'b0;
      pend_pc_q    <= RESET_PC;
      inst_valid_q <= 1'b0;
      inst_q       <= NOP_INST;
      inst_pc_q    <= '0;
    end else begin
      pc_q         <= pc_d;
      pend_q       <= imem_req;
      pend_pc_q    <= pc_q;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
    end
  end
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = inst_valid_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with an in-order stream model and literal checks
module tb_fetch_unit;
  localparam logic [31:0] K = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0, rst, stall, redirect, halt;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, inst, inst_pc;
  logic imem_req, inst_valid, halted;
  logic [31:0] addr2, rdata2, inst2, pc2;
  logic req2, vld2, halted2;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .halted(halted)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst), .imem_req(req2), .imem_addr(addr2), .imem_rdata(rdata2),
    .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0), .halt(1'b0),
    .inst(inst2), .inst_pc(pc2), .inst_valid(vld2), .halted(halted2)
  );

  // memory: word at address a is a ^ K, returned one cycle after the request
  always @(posedge clk) begin
    imem_rdata <= imem_req ? (imem_addr ^ K) : 32'hDEAD_BEEF;
    rdata2     <= req2 ? (addr2 ^ K) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // stream model: outputs form the in-order sequence of fetched PCs, held while stalled,
  // restarted at the target on redirect, frozen empty once halted
  logic [31:0] exp_pc, prev_pc, prev_inst;
  bit live = 0, hold_prev = 0, m_halted = 0;
  always @(negedge clk) begin
    if (live) begin
      chk("m_halted", {31'b0, halted}, {31'b0, m_halted});
      chk("m_align", {30'b0, imem_addr[1:0]}, 32'h0);
      if (m_halted) begin
        chk("m_halt_vld", {31'b0, inst_valid}, 32'h0);
        chk("m_halt_req", {31'b0, imem_req}, 32'h0);
      end
      if (hold_prev) begin
        chk("m_hold_vld", {31'b0, inst_valid}, 32'h1);
        chk("m_hold_pc", inst_pc, prev_pc);
        chk("m_hold_inst", inst, prev_inst);
      end else if (inst_valid) begin
        chk("m_seq_pc", inst_pc, exp_pc);
        chk("m_data", inst, inst_pc ^ K);
        exp_pc = exp_pc + 32'd4;
      end else begin
        chk("m_nop", inst, NOP);
      end
    end
    hold_prev = inst_valid & stall & !rst & !redirect & !halt & !m_halted;
    prev_pc   = inst_pc;
    prev_inst = inst;
    if (rst) begin
      live = 1;
      exp_pc = 32'h0;
      m_halted = 0;
      hold_prev = 0;
    end else if (!m_halted && halt) begin
      m_halted = 1;
    end else if (!m_halted && redirect) begin
      exp_pc = {redirect_pc[31:2], 2'b00};
    end
  end

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  initial begin
    rst = 1; stall = 0; redirect = 0; halt = 0; redirect_pc = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    smp;
    chk("rst_vld", {31'b0, inst_valid}, 32'h0);
    chk("rst_inst", inst, NOP);
    chk("rst_pc", inst_pc, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    chk("c0_req", {31'b0, imem_req}, 32'h1);
    chk("c0_addr", imem_addr, 32'h0);
    nxt; smp;
    chk("c1_req", {31'b0, imem_req}, 32'h1);
    chk("c1_addr", imem_addr, 32'h4);
    chk("c1_vld", {31'b0, inst_valid}, 32'h0);
    nxt; smp;
    chk("c2_vld", {31'b0, inst_valid}, 32'h1);
    chk("c2_pc", inst_pc, 32'h0);
    chk("c2_inst", inst, 32'hA5A5_0000);
    chk("c2_addr", imem_addr, 32'h8);
    chk("wrap_pc0", pc2, 32'hFFFF_FFF8);
    chk("wrap_inst0", inst2, 32'h5A5A_FFF8);
    nxt; smp;
    chk("c3_pc", inst_pc, 32'h4);
    chk("c3_inst", inst, 32'hA5A5_0004);
    chk("c3_req", {31'b0, imem_req}, 32'h1);
    chk("wrap_pc1", pc2, 32'hFFFF_FFFC);
    nxt; stall = 1; smp;
    chk("c4_pc", inst_pc, 32'h8);
    chk("c4_inst", inst, 32'hA5A5_0008);
    chk("c4_req", {31'b0, imem_req}, 32'h0);
    chk("wrap_pc2", pc2, 32'h0);
    chk("wrap_inst2", inst2, 32'hA5A5_0000);
    for (int i = 0; i < 2; i++) begin
      nxt; smp;
      chk("stall_pc", inst_pc, 32'h8);
      chk("stall_vld", {31'b0, inst_valid}, 32'h1);
      chk("stall_req", {31'b0, imem_req}, 32'h0);
    end
    nxt; stall = 0; smp;
    chk("c7_pc", inst_pc, 32'h8);
    chk("c7_bubble_req", {31'b0, imem_req}, 32'h0);
    nxt; smp;
    chk("c8_pc", inst_pc, 32'hC);
    chk("c8_inst", inst, 32'hA5A5_000C);
    chk("c8_addr", imem_addr, 32'h10);
    chk("c8_req", {31'b0, imem_req}, 32'h1);
    nxt; smp;
    chk("c9_vld", {31'b0, inst_valid}, 32'h0);
    nxt; smp;
    chk("c10_pc", inst_pc, 32'h10);
    chk("c10_addr", imem_addr, 32'h18);
    nxt; redirect = 1; redirect_pc = 32'h103; stall = 1; smp;
    chk("c11_pc", inst_pc, 32'h14);
    chk("c11_req", {31'b0, imem_req}, 32'h0);
    chk("c11_addr", imem_addr, 32'h1C);
    nxt; redirect = 0; stall = 0; smp;
    chk("c12_vld", {31'b0, inst_valid}, 32'h0);
    chk("c12_req", {31'b0, imem_req}, 32'h1);
    chk("c12_addr", imem_addr, 32'h100);
    nxt; smp;
    chk("c13_vld", {31'b0, inst_valid}, 32'h0);
    chk("c13_addr", imem_addr, 32'h104);
    nxt; smp;
    chk("c14_vld", {31'b0, inst_valid}, 32'h1);
    chk("c14_pc", inst_pc, 32'h100);
    chk("c14_inst", inst, 32'hA5A5_0100);
    nxt; smp;
    chk("c15_pc", inst_pc, 32'h104);
    nxt; halt = 1; redirect = 1; redirect_pc = 32'h200; smp;
    chk("c16_pc", inst_pc, 32'h108);
    chk("c16_req", {31'b0, imem_req}, 32'h0);
    for (int i = 0; i < 20; i++) begin
      nxt; halt = 0; redirect = (i == 3); redirect_pc = 32'h300; smp;
      chk("hlt_halted", {31'b0, halted}, 32'h1);
      chk("hlt_vld", {31'b0, inst_valid}, 32'h0);
      chk("hlt_inst", inst, NOP);
      chk("hlt_req", {31'b0, imem_req}, 32'h0);
      chk("hlt_addr", imem_addr, 32'h110);
    end
    nxt; redirect = 0; rst = 1; smp;
    nxt; rst = 0; smp;
    chk("r0_halted", {31'b0, halted}, 32'h0);
    chk("r0_vld", {31'b0, inst_valid}, 32'h0);
    chk("r0_addr", imem_addr, 32'h0);
    chk("r0_req", {31'b0, imem_req}, 32'h1);
    nxt; smp;
    nxt; stall = 1; smp;
    chk("r2_pc", inst_pc, 32'h0);
    chk("r2_vld", {31'b0, inst_valid}, 32'h1);
    chk("r2_req", {31'b0, imem_req}, 32'h0);
    nxt; rst = 1; smp;
    chk("r3_pc", inst_pc, 32'h0);
    chk("r3_req", {31'b0, imem_req}, 32'h0);
    nxt; rst = 0; smp;
    chk("r4_vld", {31'b0, inst_valid}, 32'h0);
    chk("r4_halted", {31'b0, halted}, 32'h0);
    chk("r4_addr", imem_addr, 32'h0);
    chk("r4_skid_empty_req", {31'b0, imem_req}, 32'h1);
    nxt; stall = 0; smp;
    chk("r5_addr", imem_addr, 32'h4);
    chk("r5_vld", {31'b0, inst_valid}, 32'h0);
    nxt; smp;
    chk("r6_pc", inst_pc, 32'h0);
    chk("r6_inst", inst, 32'hA5A5_0000);
    nxt; smp;
    chk("r7_pc", inst_pc, 32'h4);
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage of the single-issue rv32i core; sits directly upstream of the decoder.
- Owns the PC register and drives a synchronous instruction memory with a fixed 1-cycle read latency.
- Presents one registered instruction word plus its PC to the decoder each cycle.
- Handles downstream stall (1-entry skid buffer), control-flow redirect from execute, and halt.

Parameters:
RESET_PC, 32'h0000_0000, PC of the first fetch after reset
NOP_INST, 32'h0000_0013, word driven on inst when inst_valid=0 (ADDI x0,x0,0)

Ports:
clk  in  1  single core clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
imem_req  out  1  read strobe to instruction memory
imem_addr  out  32  read address; bits[1:0] always 0
imem_rdata  in  32  read data; valid exactly one cycle after imem_req=1
stall  in  1  decoder/execute cannot accept a new instruction this cycle
redirect  in  1  taken branch/jump; flush and refetch
redirect_pc  in  32  target PC; bits[1:0] ignored (forced to 0)
halt  in  1  halt request from downstream (is_halt path)
inst  out  32  instruction to decoder
inst_pc  out  32  PC of inst
inst_valid  out  1  inst/inst_pc hold a live instruction
halted  out  1  fetch stopped; only rst leaves this state

Behaviour:
- Reset (rst=1 at edge): pc_q=RESET_PC, state=RUN, pend_q=0, skid_valid=0, inst_valid=0, inst=NOP_INST, inst_pc=0, halted=0. Reset overrides everything, including mid-stall or pending reads.
- States: RUN, HALTED. RUN->HALTED when halt=1. HALTED->RUN only via rst.
- Request rule (RUN): imem_req = !skid_valid & !(stall & inst_valid) & !redirect & !halt. On request: imem_addr=pc_q, pc_q<=pc_q+4 (mod 2^32, 0xFFFF_FFFC wraps to 0), pend_q<=1, pend_pc_q<=pc_q. Otherwise pend_q<=0. At most one read outstanding.
- Output load: the output register loads when !(inst_valid & stall). Source priority: skid entry, then arriving response (pend_q=1), else inst_valid<=0 and inst<=NOP_INST.
- Skid: a response arriving while the output cannot load is captured in skid (inst, pc). When stall drops, skid moves to the output; no new request is issued that cycle (one-cycle bubble is accepted).
- Hold: while inst_valid=1 and stall=1, inst/inst_pc/inst_valid are stable.
- Latency: reset release at cycle 0 -> req RESET_PC in cycle 0 -> inst_valid=1 with inst_pc=RESET_PC in cycle 2. Steady state without stall: one instruction per cycle.
- Redirect (RUN, redirect=1): pc_q<={redirect_pc[31:2],2'b00}; the pending response is dropped; skid cleared; inst_valid<=0; no request that cycle. First request at the target in the next cycle; target valid at the output 3 cycles after the redirect cycle. Redirect overrides stall.
- Halt: halt=1 -> state=HALTED; the pending response is dropped; skid cleared; inst_valid<=0, inst=NOP_INST, halted<=1 next cycle; imem_req=0 thereafter. halt and redirect in the same cycle: halt wins. redirect ignored in HALTED.
- imem_addr=pc_q whenever imem_req=0 (don't-care to memory; kept deterministic for the bench).

Decomposition:
- Shared package (rv32i_pkg): RESET_PC default, NOP_INST, fetch state enum {RUN, HALTED}, 32-bit word/PC typedefs.
- Sub-module fetch_skid_buf: 1-entry {inst, pc} holding register with load/clear/valid; the rest of the logic stays in fetch_unit.

Test Plan:
1. Reset release, memory returns rdata=addr^32'hA5A5_0000, no stall -> inst_pc 0,4,8 in cycles 2,3,4; inst 0xA5A5_0000, 0xA5A5_0004, 0xA5A5_0008; imem_req continuously 1.
2. stall=1 for 3 cycles while inst_pc=8 is valid and a read of 0xC is pending -> output holds 8, skid holds 0xC, imem_req=0; after release, 0xC appears next, then 0x10 after the one-cycle bubble; no loss or duplication.
3. redirect=1, redirect_pc=0x103 with a read pending -> pending word never reaches the output; inst_valid=0 for 2 cycles; imem_addr=0x100 next cycle; inst_pc=0x100 3 cycles after the redirect.
4. halt=1 mid-stream (with redirect=1 in the same cycle) -> halted=1 next cycle, inst_valid=0, inst=0x0000_0013, imem_req=0 for 20 cycles; redirect ignored.
5. RESET_PC=32'hFFFF_FFF8 -> inst_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
6. rst=1 during stall with a full skid -> next cycle inst_valid=0, skid empty, halted=0, imem_addr=RESET_PC.
